// File: rtl/uart_tx_port.sv
// ============================================================================
// Module   : uart_tx_port
// Purpose  : CPU output-port UART transmitter. Bytes from the port write
//            strobe are queued in a small FIFO and sent as 8N1 frames on tx.
//            A status byte {5'b0, ovf, full, busy} is read back for polling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic [7:0] status
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  c_cnt_full  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_baud_done;

  // Full check uses the pre-edge count, so a pop on the same edge never
  // rescues a write into a full FIFO.
  assign w_full      = (count_q == c_cnt_full);
  assign w_push      = wr_en && !w_full;
  assign w_pop       = (state_q == c_st_idle) && (count_q != '0);
  assign w_baud_done = (baud_q == c_baud_last);

  // FIFO storage, pointers, occupancy and sticky overflow next-state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - CNT_W'(1);
    end
    // Setting wins over a coincident clear.
    if (wr_en && w_full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      c_st_idle: begin
        tx_d = 1'b1;
        if (w_pop) begin
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = c_st_start;
          tx_d    = 1'b0;
        end
      end
      c_st_start: begin
        if (w_baud_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = c_st_data;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      c_st_data: begin
        if (w_baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = c_st_stop;
            tx_d    = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        tx_d = 1'b1;
        if (w_baud_done) begin
          baud_d  = '0;
          state_d = c_st_idle;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any frame
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= c_st_idle;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx     = tx_q;
  assign busy   = (state_q != c_st_idle) || (count_q != '0);
  assign status = {5'b00000, ovf_q, w_full, busy};

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_port.sv
// ============================================================================
// Module   : tb_uart_tx_port
// Purpose  : Directed self-checking bench for uart_tx_port (C=4, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_port;

  localparam int C = 4;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic [7:0] status;

  int total;
  int bad;

  uart_tx_port #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .clr_ovf(clr_ovf),
    .tx     (tx),
    .busy   (busy),
    .status (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle write strobe; returns settled after the write edge.
  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  // Checks tx/busy for frame cycles first_c..10C-1, where cycle 0 is the
  // state just after the start edge. Returns settled after edge start+10C.
  task automatic recv_frame(input string tag, input logic [7:0] b, input int first_c);
    logic exp_bit;
    for (int c = first_c; c < 10*C; c++) begin
      if (c < C)        exp_bit = 1'b0;
      else if (c >= 9*C) exp_bit = 1'b1;
      else              exp_bit = b[(c / C) - 1];
      chk($sformatf("%s_tx_c%0d", tag, c), {7'b0, tx}, {7'b0, exp_bit});
      chk($sformatf("%s_busy_c%0d", tag, c), {7'b0, busy}, 8'h01);
      tick();
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;

    // ---- reset and idle
    tick();
    tick();
    reset = 1'b0;
    chk("rst_tx", {7'b0, tx}, 8'h01);
    chk("rst_status", status, 8'h00);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_tx", {7'b0, tx}, 8'h01);
      chk("idle_status", status, 8'h00);
    end

    // ---- single byte A5
    write_byte(8'hA5);
    chk("a5_wr_status", status, 8'h01);
    chk("a5_wr_tx", {7'b0, tx}, 8'h01);
    tick();
    recv_frame("a5", 8'hA5, 0);
    chk("a5_busy_end", {7'b0, busy}, 8'h00);
    chk("a5_tx_end", {7'b0, tx}, 8'h01);

    // ---- five writes fill to full, sixth overflows
    write_byte(8'h01);      // edge N, popped at N+1 (frame start)
    write_byte(8'h02);      // frame cycle 0
    write_byte(8'h03);
    write_byte(8'h04);
    write_byte(8'h05);      // frame cycle 3
    chk("fill_full", status, 8'h03);
    write_byte(8'h06);      // frame cycle 4, dropped
    chk("fill_ovf", status, 8'h07);
    recv_frame("f01", 8'h01, 4);
    chk("f01_gap_tx", {7'b0, tx}, 8'h01);
    chk("f01_gap_busy", {7'b0, busy}, 8'h01);
    tick();
    recv_frame("f02", 8'h02, 0);
    chk("f02_gap_tx", {7'b0, tx}, 8'h01);
    tick();
    recv_frame("f03", 8'h03, 0);
    chk("f03_gap_tx", {7'b0, tx}, 8'h01);
    tick();
    recv_frame("f04", 8'h04, 0);
    chk("f04_gap_tx", {7'b0, tx}, 8'h01);
    tick();
    recv_frame("f05", 8'h05, 0);
    chk("f05_status_end", status, 8'h04);
    for (int i = 0; i < 45; i++) begin
      tick();
      chk("no_f06_tx", {7'b0, tx}, 8'h01);
    end

    // ---- clr_ovf pulse
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", status, 8'h00);

    // ---- clr_ovf coincident with overflowing write: set wins
    write_byte(8'h10);
    write_byte(8'h11);
    write_byte(8'h12);
    write_byte(8'h13);
    write_byte(8'h14);
    chk("co_full", status, 8'h03);
    clr_ovf = 1'b1;
    write_byte(8'h15);
    clr_ovf = 1'b0;
    chk("co_set_wins", status, 8'h07);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("co_clear", status, 8'h03);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("co_rst_status", status, 8'h00);

    // ---- reset during bit 3 with two bytes queued
    write_byte(8'hF0);      // popped next edge
    write_byte(8'h33);      // frame cycle 0
    write_byte(8'h44);      // frame cycle 1
    for (int i = 0; i < 16; i++) tick();   // frame cycle 17, bit 3
    chk("mid_bit3", {7'b0, tx}, 8'h00);
    chk("mid_status", status, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_tx", {7'b0, tx}, 8'h01);
    chk("mid_rst_status", status, 8'h00);
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("mid_quiet_tx", {7'b0, tx}, 8'h01);
      chk("mid_quiet_status", status, 8'h00);
    end

    // ---- push on the same edge as a pop with 3 entries held
    write_byte(8'h5A);      // popped next edge
    write_byte(8'hC3);      // frame cycle 0, count 1
    write_byte(8'h81);      // count 2
    write_byte(8'h7E);      // frame cycle 2, count 3
    recv_frame("p5a", 8'h5A, 2);
    write_byte(8'h96);      // coincides with pop of C3
    chk("pp_no_ovf", status, 8'h01);
    write_byte(8'h2B);      // frame cycle 1, count reaches 4
    chk("pp_full", status, 8'h03);
    recv_frame("pc3", 8'hC3, 1);
    tick();
    recv_frame("p81", 8'h81, 0);
    tick();
    recv_frame("p7e", 8'h7E, 0);
    tick();
    recv_frame("p96", 8'h96, 0);
    tick();
    recv_frame("p2b", 8'h2B, 0);
    chk("pp_end_status", status, 8'h00);
    chk("pp_end_tx", {7'b0, tx}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
